// File: rtl/iob_picorv32_wbuf_pkg.sv
// Shared types for the PicoRV32 posted-write buffer: read FSM encoding and FIFO entry width.
package iob_picorv32_wbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_DRAIN = 2'd1,
    ST_RD_REQ   = 2'd2,
    ST_RD_WAIT  = 2'd3
  } wbuf_state_e;

  // Entry layout is {addr, wdata, wstrb}.
  function automatic int wbuf_entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_picorv32_wbuf_fifo.sv
// Register-array FIFO with synchronous reset and clock enable; pointers wrap modulo depth.
module iob_picorv32_wbuf_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [W-1:0]          data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_LAST  = (DEPTH_LOG2 + 1)'(DEPTH - 1);
  localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [W-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr, r_rptr, r_count;
  logic                w_push, w_pop;

  assign full_o  = (r_count == C_DEPTH);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (cke_i) begin
      if (w_push) r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= data_i;
  end

endmodule

// File: rtl/iob_picorv32_wbuf.sv
// Posted-write buffer: stores are acked into a FIFO and drained in the background;
// loads wait for the FIFO to empty and then go out as a single outstanding read.
module iob_picorv32_wbuf
  import iob_picorv32_wbuf_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                s_avalid_i,
  input  logic [ADDR_W-1:0]   s_addr_i,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic [DATA_W/8-1:0] s_wstrb_i,
  output logic                s_ready_o,
  output logic [DATA_W-1:0]   s_rdata_o,
  output logic                s_rvalid_o,
  output logic                m_avalid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  output logic                empty_o
);
  localparam int ENTRY_W = wbuf_entry_w(ADDR_W, DATA_W);

  wbuf_state_e         r_state;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;

  logic                w_is_write, w_is_read, w_drain, w_push, w_pop;
  logic                w_full, w_fifo_empty;
  logic [DEPTH_LOG2:0] w_count;
  logic [ENTRY_W-1:0]  w_head;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_wdata;
  logic [DATA_W/8-1:0] w_head_wstrb;

  assign {w_head_addr, w_head_wdata, w_head_wstrb} = w_head;

  assign w_is_write = s_avalid_i & (|s_wstrb_i);
  assign w_is_read  = s_avalid_i & ~(|s_wstrb_i);
  // The FIFO keeps draining while a read waits behind it.
  assign w_drain    = ~w_fifo_empty & ((r_state == ST_IDLE) | (r_state == ST_RD_DRAIN));
  assign w_push     = w_is_write & ~w_full & (r_state == ST_IDLE);
  assign w_pop      = w_drain & m_ready_i;

  iob_picorv32_wbuf_fifo #(
    .W          (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  ({s_addr_i, s_wdata_i, s_wstrb_i}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_fifo_empty),
    .count_o (w_count)
  );

  always_comb begin
    s_ready_o  = 1'b0;
    m_avalid_o = 1'b0;
    m_addr_o   = '0;
    m_wdata_o  = '0;
    m_wstrb_o  = '0;
    if (w_drain) begin
      m_avalid_o = 1'b1;
      m_addr_o   = w_head_addr;
      m_wdata_o  = w_head_wdata;
      m_wstrb_o  = w_head_wstrb;
    end
    case (r_state)
      ST_IDLE:   s_ready_o = w_push;
      ST_RD_REQ: begin
        s_ready_o  = m_ready_i;
        m_avalid_o = 1'b1;
        m_addr_o   = s_addr_i;
      end
      default:   s_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (cke_i) begin
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE:     if (w_is_read) r_state <= w_fifo_empty ? ST_RD_REQ : ST_RD_DRAIN;
        ST_RD_DRAIN: if (w_count == '0) r_state <= ST_RD_REQ;
        ST_RD_REQ:   if (m_ready_i) r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (m_rvalid_i) begin
            r_rdata  <= m_rdata_i;
            r_rvalid <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_rdata_o  = r_rdata;
  assign s_rvalid_o = r_rvalid;
  assign empty_o    = w_fifo_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_iob_picorv32_wbuf.sv
// Bench for iob_picorv32_wbuf: queue/memory model checked every cycle plus directed scenarios.
module tb_iob_picorv32_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        cke_i = 1'b1, rst_i = 1'b1;
  logic        s_avalid_i = 1'b0;
  logic [29:0] s_addr_i = '0;
  logic [31:0] s_wdata_i = '0;
  logic [3:0]  s_wstrb_i = '0;
  logic        s_ready_o, s_rvalid_o, m_avalid_o, empty_o;
  logic [31:0] s_rdata_o, m_wdata_o;
  logic [29:0] m_addr_o;
  logic [3:0]  m_wstrb_o;
  logic        m_ready_i = 1'b0, m_rvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;

  iob_picorv32_wbuf dut (
    .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
    .s_avalid_i(s_avalid_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_ready_o(s_ready_o), .s_rdata_o(s_rdata_o), .s_rvalid_o(s_rvalid_o),
    .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_ready_i(m_ready_i), .m_rdata_i(m_rdata_i), .m_rvalid_i(m_rvalid_i), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [29:0] a; logic [31:0] d; logic [3:0] s; } ent_t;
  ent_t        wq[$];
  logic [31:0] mem [logic [29:0]];
  bit          rd_phase = 0, req_live = 0, rd_out = 0, rv_due = 0;
  logic [29:0] rd_addr = '0;
  logic [31:0] rv_data = '0;
  int          lat = 1;
  bit          rsp_arm = 0;
  logic [31:0] rsp_data = '0;
  int          rsp_timer = 0;

  function automatic logic [31:0] memrd(input logic [29:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 | {16'h0, lo};
  endfunction

  always @(negedge clk) begin
    int   sz;
    bit   exp_sr, nxt_rv;
    ent_t e;
    logic [31:0] old;
    if (rst_i) begin
      wq.delete(); rd_phase = 0; req_live = 0; rd_out = 0; rv_due = 0;
    end else begin
      sz = wq.size();
      chk("empty_o", empty_o, (sz == 0 && !rd_phase));
      chk("s_rvalid_o", s_rvalid_o, rv_due);
      if (rv_due) chk("s_rdata_o", s_rdata_o, rv_data);
      chk("m_avalid_o", m_avalid_o, (sz > 0 || req_live));
      if (sz > 0) begin
        chk("m_addr_o(wr)", m_addr_o, wq[0].a);
        chk("m_wdata_o", m_wdata_o, wq[0].d);
        chk("m_wstrb_o", m_wstrb_o, wq[0].s);
      end else if (req_live) begin
        chk("m_addr_o(rd)", m_addr_o, rd_addr);
        chk("m_wstrb_o(rd)", m_wstrb_o, 4'h0);
      end
      exp_sr = req_live ? m_ready_i
                        : (!rd_phase && s_avalid_i && (s_wstrb_i != 0) && sz < DEPTH);
      chk("s_ready_o", s_ready_o, exp_sr);
      if (cke_i) begin
        if (sz > 0 && m_ready_i) begin
          e = wq.pop_front();
          old = memrd(e.a);
          for (int b = 0; b < 4; b++) if (e.s[b]) old[8*b +: 8] = e.d[8*b +: 8];
          mem[e.a] = old;
        end
        if (exp_sr && !req_live) wq.push_back('{a: s_addr_i, d: s_wdata_i, s: s_wstrb_i});
        nxt_rv = 0;
        if (rd_out && m_rvalid_i) begin
          rd_out = 0; rd_phase = 0; nxt_rv = 1; rv_data = m_rdata_i;
        end else if (req_live && m_ready_i) begin
          req_live = 0; rd_out = 1; rsp_arm = 1; rsp_data = memrd(rd_addr);
        end else if (!rd_phase && s_avalid_i && s_wstrb_i == 0) begin
          rd_phase = 1; rd_addr = s_addr_i; req_live = (sz == 0);
        end else if (rd_phase && !req_live && !rd_out && sz == 0) begin
          req_live = 1;
        end
        rv_due = nxt_rv;
      end
    end
  end

  // Memory responder: read data returns lat cycles after the accepting cycle.
  initial forever begin
    @(posedge clk); #1;
    m_rvalid_i = 1'b0;
    if (rsp_arm) begin rsp_timer = lat; rsp_arm = 0; end
    if (rsp_timer > 0) begin
      rsp_timer--;
      if (rsp_timer == 0) begin m_rvalid_i = 1'b1; m_rdata_i = rsp_data; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s, output int stalls);
    bit ok;
    ok = 0; stalls = 0;
    s_avalid_i = 1; s_addr_i = a; s_wdata_i = d; s_wstrb_i = s;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_ready_o) begin ok = 1; break; end
      stalls++;
    end
    chk("wr_handshake", ok, 1);
    @(posedge clk); #1;
    s_avalid_i = 0; s_wstrb_i = 0;
  endtask

  task automatic rd(input logic [29:0] a, output int stalls, output int lat_c, output logic [31:0] d);
    bit ok;
    ok = 0; stalls = 0; lat_c = 0; d = '0;
    s_avalid_i = 1; s_addr_i = a; s_wdata_i = '0; s_wstrb_i = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_ready_o) begin ok = 1; break; end
      stalls++;
    end
    chk("rd_handshake", ok, 1);
    @(posedge clk); #1;
    s_avalid_i = 0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat_c++;
      if (s_rvalid_o) begin ok = 1; d = s_rdata_o; break; end
    end
    chk("rd_rvalid", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (empty_o) begin ok = 1; break; end
    end
    chk("wait_empty", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_i = 1; @(posedge clk); #1; rst_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, lc, pulses;
    logic [31:0] d;
    repeat (2) @(posedge clk); #1;
    rst_i = 0;
    // Reset values
    chk("rst s_ready_o", s_ready_o, 0);
    chk("rst s_rvalid_o", s_rvalid_o, 0);
    chk("rst s_rdata_o", s_rdata_o, 0);
    chk("rst m_avalid_o", m_avalid_o, 0);
    chk("rst m_addr_o", m_addr_o, 0);
    chk("rst m_wstrb_o", m_wstrb_o, 0);
    chk("rst empty_o", empty_o, 1);

    // Single write
    m_ready_i = 1;
    wr(30'h10, 32'hDEADBEEF, 4'hF, st);
    chk("t1 stalls", st, 0);
    chk("t1 m_avalid", m_avalid_o, 1);
    chk("t1 m_addr", m_addr_o, 30'h10);
    chk("t1 m_wdata", m_wdata_o, 32'hDEADBEEF);
    chk("t1 m_wstrb", m_wstrb_o, 4'hF);
    @(posedge clk); #1;
    chk("t1 empty", empty_o, 1);

    // Fill to full, fifth write stalls until downstream accepts
    m_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      wr(30'h100 + 30'(i), 32'hA000_0000 + 32'(i), 4'hF, st);
      chk("t2 stalls", st, 0);
    end
    s_avalid_i = 1; s_addr_i = 30'h104; s_wdata_i = 32'hA000_0004; s_wstrb_i = 4'h3;
    repeat (3) begin @(negedge clk); chk("t2 full stall", s_ready_o, 0); end
    @(posedge clk); #1; m_ready_i = 1;
    @(negedge clk);
    chk("t2 no bypass", s_ready_o, 0);
    chk("t2 head0", m_addr_o, 30'h100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2 accept5", s_ready_o, 1);
    chk("t2 head1", m_addr_o, 30'h101);
    @(posedge clk); #1; s_avalid_i = 0; s_wstrb_i = 0;
    wait_empty();

    // Read behind three writes, memory latency 2
    m_ready_i = 0;
    for (int i = 0; i < 3; i++) wr(30'h200 + 30'(i), 32'hB000_0000 + 32'(i), 4'hF, st);
    lat = 2; m_ready_i = 1;
    rd(30'h20, st, lc, d);
    chk("t3 read stalls", st, 4);
    chk("t3 read latency", lc, 3);
    chk("t3 read data", d, 32'hC0DE0020);

    // Read-after-write ordering
    lat = 1;
    wr(30'h4, 32'h0000_55AA, 4'hF, st);
    rd(30'h4, st, lc, d);
    chk("t4 raw data", d, 32'h0000_55AA);
    chk("t4 stalls", st, 2);
    chk("t4 latency", lc, 2);

    // Reset with buffered writes
    m_ready_i = 0;
    wr(30'h400, 32'h1111_1111, 4'hF, st);
    wr(30'h401, 32'h2222_2222, 4'hF, st);
    pulse_reset();
    chk("t5 m_avalid", m_avalid_o, 0);
    chk("t5 empty", empty_o, 1);
    chk("t5 s_rvalid", s_rvalid_o, 0);

    // Reset with a read in flight; the late response must be ignored
    lat = 6; m_ready_i = 1;
    s_avalid_i = 1; s_addr_i = 30'h30; s_wstrb_i = 0;
    st = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_ready_o) begin st = 1; break; end end
    chk("t5 rd accept", st, 1);
    @(posedge clk); #1; s_avalid_i = 0;
    @(posedge clk); #1;
    pulse_reset();
    pulses = 0;
    repeat (10) begin @(negedge clk); if (s_rvalid_o) pulses++; end
    chk("t5 stray rvalid", pulses, 0);
    chk("t5 empty after", empty_o, 1);
    @(posedge clk); #1;

    // Clock-enable freeze during a drain
    lat = 1; m_ready_i = 0;
    for (int i = 0; i < 3; i++) wr(30'h300 + 30'(i), 32'hC000_0000 + 32'(i), 4'h5, st);
    cke_i = 0; m_ready_i = 1;
    repeat (5) begin
      @(negedge clk);
      chk("t6 frozen avalid", m_avalid_o, 1);
      chk("t6 frozen head", m_addr_o, 30'h300);
      chk("t6 frozen empty", empty_o, 0);
    end
    @(posedge clk); #1; cke_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6 drain order", m_addr_o, 30'h300 + 30'(i));
    end
    @(negedge clk);
    chk("t6 empty", empty_o, 1);
    @(posedge clk); #1;
    m_ready_i = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
